afifo_rd_stream: RTL and testbench

Read-side consumer stage for the asynchronous FIFO. Sits in the read clock domain directly downstream of the FIFO read port (rinc/rempty/rdata). It pops words whenever it has room and presents them on a registered valid/ready stream with a two-entry output buffer. Downstream back-pressure never reaches the FIFO combinationally, and throughput is one word per cycle.

---
 rtl/afifo_rd_stream.sv | 88 ++++++++
 tb/tb_afifo_rd_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_stream.sv
// Read-side consumer for the async FIFO: pops show-ahead words into a
// two-entry head/skid buffer and presents them as a registered valid/ready stream.
module afifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  push, take;

    // Pop decision uses only local state, so m_ready never reaches the FIFO.
    assign rinc      = en && !rempty && (state_q != TWO) && !rrst;
    assign push      = rinc;
    assign m_valid   = (state_q != EMPTY);
    assign take      = m_valid && m_ready;
    assign m_data    = head_q;
    assign occupancy = state_q;
    assign word_cnt  = word_cnt_q;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        word_cnt_d = word_cnt_q + CNT_WIDTH'(take);
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = rdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && take) begin
                    head_d = rdata;
                end else if (push) begin
                    skid_d  = rdata;
                    state_d = TWO;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Skid always follows head, keeping strict FIFO order.
                if (take) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: array-backed FIFO model, queue scoreboard of popped
// words checked by a negedge monitor, directed phases followed by random traffic.
module tb_afifo_rd_stream;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int FDEP = 4096;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          en;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] word_cnt;

    afifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .occupancy(occupancy), .word_cnt(word_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO model: write side driven by stimulus, read pointer advances on pops.
    logic [DW-1:0] fifo_mem [FDEP];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          gap;
    logic          rinc_s = 1'b0;

    assign rempty = (rd_ptr == wr_ptr) || gap;
    assign rdata  = fifo_mem[rd_ptr % FDEP];

    always @(posedge rclk) if (rinc_s) rd_ptr <= rd_ptr + 1;

    int checks   = 0;
    int failures = 0;
    int dcnt     = 0;
    int npops    = 0;
    logic [DW-1:0] exp_q [$];
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fifo_put(input logic [DW-1:0] w);
        fifo_mem[wr_ptr % FDEP] = w;
        wr_ptr++;
    endtask

    // Monitor: expected state is just "words popped but not yet delivered".
    always @(negedge rclk) begin
        if (rrst) begin
            chk("rst_rinc", rinc, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_wcnt", word_cnt, 0);
            chk("rst_data", m_data, 0);
            exp_q.delete();
            dcnt   = 0;
            hold_v = 1'b0;
            rinc_s = 1'b0;
        end else begin
            chk("occupancy", occupancy, exp_q.size());
            chk("valid", m_valid, exp_q.size() != 0);
            chk("word_cnt", word_cnt, dcnt % (1 << CW));
            if (hold_v) chk("data_stable", m_data, hold_d);
            if (rinc) begin
                chk("no_underflow", rempty, 0);
                chk("no_overflow", exp_q.size() < 2, 1);
                chk("en_gate", en, 1);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("data_spurious", m_data, 64'hdead);
                else chk("data", m_data, exp_q.pop_front());
                dcnt++;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            rinc_s = rinc;
            if (rinc) begin
                exp_q.push_back(rdata);
                npops++;
            end
        end
    end

    task automatic tick();
        @(posedge rclk); #1;
    endtask

    task automatic do_reset();
        rrst = 1'b1; gap = 1'b1; en = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        rrst = 1'b0;
        tick();
    endtask

    initial begin
        int pops;
        int cyc;
        rrst = 1'b1; en = 1'b0; m_ready = 1'b0; gap = 1'b1;
        do_reset();

        // Streaming: 0x10..0x1F, gapless, one cycle pop-to-visible.
        for (int i = 0; i < 16; i++) fifo_put(DW'(32'h10 + i));
        m_ready = 1'b1; gap = 1'b0; en = 1'b1;
        @(negedge rclk);
        chk("stream_first_rinc", rinc, 1);
        chk("stream_not_yet_valid", m_valid, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge rclk);
            chk("stream_gapless", m_valid, 1);
            chk("stream_word", m_data, 32'h10 + i);
        end
        @(negedge rclk);
        chk("stream_wcnt_wrap16", word_cnt, 0);
        chk("stream_done_valid", m_valid, 0);

        // Back-pressure mid-stream.
        for (int i = 0; i < 24; i++) fifo_put($urandom);
        repeat (4) tick();
        m_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            if (rinc) pops++;
            @(posedge rclk); #1;
        end
        chk("bp_pops", (pops >= 1) && (pops <= 2), 1);
        chk("bp_rinc_low", rinc, 0);
        chk("bp_occ", occupancy, 2);

        // Reset with a full buffer: everything clears at once.
        rrst = 1'b1;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_wcnt", word_cnt, 0);
        chk("arst_rinc", rinc, 0);
        gap = 1'b1;
        repeat (2) tick();
        rrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rinc", rinc, 0);
        end

        // Restore m_ready after back-pressure: scoreboard checks order.
        gap = 1'b0; m_ready = 1'b1; en = 1'b1;
        repeat (6) tick();
        m_ready = 1'b0;
        repeat (4) tick();
        m_ready = 1'b1;
        repeat (4) tick();

        // Enable drop with a full buffer.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_put($urandom);
        cyc = 0;
        while (occupancy != 2 && cyc < 20) begin tick(); cyc++; end
        chk("en_fill_timeout", occupancy, 2);
        en = 1'b0; m_ready = 1'b1;
        cyc = 0;
        while (occupancy != 0 && cyc < 20) begin tick(); cyc++; end
        chk("en_drained", occupancy, 0);
        en = 1'b1;
        #1;
        chk("en_resume_rinc", rinc, 1);
        tick();

        // Counter wrap: 17 deliveries after reset read as 1.
        do_reset();
        for (int i = 0; i < 20; i++) fifo_put($urandom);
        gap = 1'b0; en = 1'b1; m_ready = 1'b1;
        cyc = 0;
        while (dcnt != 17 && cyc < 60) begin @(posedge rclk); #2; cyc++; end
        m_ready = 1'b0; en = 1'b0;
        chk("wrap_reached17", dcnt, 17);
        chk("wrap_wcnt", word_cnt, 1);
        tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            tick();
            gap     = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) fifo_put($urandom);
        end
        gap = 1'b0; en = 1'b1; m_ready = 1'b1;
        cyc = 0;
        while ((rd_ptr != wr_ptr || exp_q.size() != 0 || occupancy != 0) && cyc < 3000) begin
            tick(); cyc++;
        end
        chk("drain_fifo_empty", rd_ptr == wr_ptr, 1);
        chk("drain_scoreboard_empty", exp_q.size(), 0);
        chk("drain_occ", occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
